// File: rtl/eda_regional_max_pkg.sv
// Shared constants for the regional-max neighbourhood: lane count, lane index type, 3x3 neighbour offsets.
// Latency: n/a (declarations only).
// Backpressure: n/a. Also supplies default CFG_* geometry macros when the build does not set them.
`ifndef CFG_WINDOW_WIDTH
`define CFG_WINDOW_WIDTH 9
`endif
`ifndef CFG_I_WIDTH
`define CFG_I_WIDTH 4
`endif
`ifndef CFG_J_WIDTH
`define CFG_J_WIDTH 4
`endif
`ifndef CFG_ADDR_WIDTH
`define CFG_ADDR_WIDTH 8
`endif

package eda_regional_max_pkg;
   // One lane per neighbour of the centre pixel (window minus the centre itself).
   localparam int N_LANES = 8;

   typedef logic [$clog2(N_LANES)-1:0] lane_idx_t;

   // Lane -> (drow, dcol): row above left to right, same row left/right, row below left to right.
   localparam int LANE_DROW [N_LANES] = '{-1, -1, -1,  0,  0,  1,  1,  1};
   localparam int LANE_DCOL [N_LANES] = '{-1,  0,  1, -1,  1, -1,  0,  1};
endpackage

// File: rtl/eda_fifo_bank_if.sv
// Handshake/bus bundle between a pusher/reader and the neighbour-address FIFO bank.
// Latency: n/a (wires only).
// Backpressure: reader sees per-lane empty/full; pushes into a full lane are dropped by the bank.
interface eda_fifo_bank_if #(
   parameter int WINDOW_WIDTH = `CFG_WINDOW_WIDTH,
   parameter int ADDR_WIDTH   = `CFG_ADDR_WIDTH
);
   localparam int N = WINDOW_WIDTH - 1;

   logic                  clear;
   logic [ADDR_WIDTH-1:0] center_addr;
   logic [N-1:0]          push_positions;
   logic [N-1:0]          read_en;
   logic [ADDR_WIDTH-1:0] data_out;
   logic [N-1:0]          fifo_empty;
   logic [N-1:0]          fifo_full;

   modport master (
      output clear, center_addr, push_positions, read_en,
      input  data_out, fifo_empty, fifo_full
   );

   modport slave (
      input  clear, center_addr, push_positions, read_en,
      output data_out, fifo_empty, fifo_full
   );
endinterface

// File: rtl/eda_addr_fifo.sv
// One address lane: first-word fall-through FIFO with registered empty/full and synchronous clear.
// Latency: head valid the cycle after the push; pop takes effect at the clock edge.
// Backpressure: push into a full lane is dropped unless the lane pops in the same cycle; pop on empty ignored.
// Optional EDA_FIFO_BANK_OVF_CHECK_EN adds a drop strobe for the bank-level overflow flag.
module eda_addr_fifo #(
   parameter int AW    = 8,
   parameter int DEPTH = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          push,
   input  logic          pop,
   input  logic [AW-1:0] din,
   output logic [AW-1:0] head,
   output logic          empty,
   output logic          full
`ifdef EDA_FIFO_BANK_OVF_CHECK_EN
   ,
   output logic          drop
`endif
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic [CW-1:0] next_cnt;
   logic          pop_ok;
   logic          push_ok;

   // A pop on a full lane frees the slot the concurrent push needs.
   assign pop_ok   = pop & ~empty;
   assign push_ok  = push & (~full | pop_ok);
   assign next_cnt = cnt + CW'(push_ok) - CW'(pop_ok);
   assign head     = mem[rd_ptr];

`ifdef EDA_FIFO_BANK_OVF_CHECK_EN
   // Clear discards the push anyway, so it is not counted as an overflow.
   assign drop = push & full & ~pop_ok & ~clear;
`endif

   // Storage write; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers, occupancy and registered status; clear beats push/pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         cnt   <= next_cnt;
         empty <= (next_cnt == '0);
         full  <= (next_cnt == CW'(DEPTH));
      end
   end
endmodule

// File: rtl/eda_fifo_bank.sv
// Bank of N neighbour-address FIFOs: pushes centre+offset per lane, pops the lowest requested lane.
// Latency: data_out is combinational from the selected head; pushed entries visible next cycle.
// Backpressure: per-lane registered empty/full; full-lane pushes dropped (sticky ovf_err with EDA_FIFO_BANK_OVF_CHECK_EN).
module eda_fifo_bank
   import eda_regional_max_pkg::*;
#(
   parameter int WINDOW_WIDTH = `CFG_WINDOW_WIDTH,
   parameter int ADDR_WIDTH   = `CFG_ADDR_WIDTH,
   parameter int I_WIDTH      = `CFG_I_WIDTH,
   parameter int J_WIDTH      = `CFG_J_WIDTH,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic            clk,
   input  logic            reset,
   eda_fifo_bank_if.slave  bus
`ifdef EDA_FIFO_BANK_OVF_CHECK_EN
   ,
   output logic            ovf_err
`endif
);
   localparam int N = WINDOW_WIDTH - 1;

   logic [I_WIDTH-1:0]    row;
   logic [J_WIDTH-1:0]    col;
   logic [ADDR_WIDTH-1:0] heads [N];
   logic [N-1:0]          lane_empty;
   logic [N-1:0]          lane_full;
   logic [N-1:0]          lane_pop;
   lane_idx_t             sel;
   logic                  sel_vld;
`ifdef EDA_FIFO_BANK_OVF_CHECK_EN
   logic [N-1:0]          lane_drop;
`endif

   assign row = bus.center_addr[ADDR_WIDTH-1:J_WIDTH];
   assign col = bus.center_addr[J_WIDTH-1:0];

   // Lowest set read_en bit wins; scanning downward leaves the lowest index last.
   always_comb begin
      sel     = '0;
      sel_vld = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (bus.read_en[i]) begin
            sel     = lane_idx_t'(i);
            sel_vld = 1'b1;
         end
      end
   end

   // Only the selected lane receives a pop.
   always_comb begin
      lane_pop = '0;
      if (sel_vld) begin
         lane_pop[sel] = 1'b1;
      end
   end

   assign bus.data_out   = (sel_vld && !lane_empty[sel]) ? heads[sel] : '0;
   assign bus.fifo_empty = lane_empty;
   assign bus.fifo_full  = lane_full;

   for (genvar g = 0; g < N; g++) begin : g_lane
      // Offsets wrap modulo the field width; the pusher owns range checking.
      localparam logic [I_WIDTH-1:0] DR = I_WIDTH'(LANE_DROW[g]);
      localparam logic [J_WIDTH-1:0] DC = J_WIDTH'(LANE_DCOL[g]);

      logic [ADDR_WIDTH-1:0] din;
      assign din = {row + DR, col + DC};

      eda_addr_fifo #(
         .AW    (ADDR_WIDTH),
         .DEPTH (FIFO_DEPTH)
      ) u_lane (
         .clk   (clk),
         .reset (reset),
         .clear (bus.clear),
         .push  (bus.push_positions[g]),
         .pop   (lane_pop[g]),
         .din   (din),
         .head  (heads[g]),
         .empty (lane_empty[g]),
         .full  (lane_full[g])
`ifdef EDA_FIFO_BANK_OVF_CHECK_EN
         ,
         .drop  (lane_drop[g])
`endif
      );
   end

`ifdef EDA_FIFO_BANK_OVF_CHECK_EN
   // Sticky overflow flag: set by any dropped push, cleared only by clear or reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_err <= 1'b0;
      end else if (bus.clear) begin
         ovf_err <= 1'b0;
      end else if (|lane_drop) begin
         ovf_err <= 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_eda_fifo_bank.sv
// Directed bench for eda_fifo_bank: vector table plus fill/overflow, full push+pop and reset sequences.
// Latency: inputs driven at negedge, data_out sampled 1ns later, status sampled 1ns after posedge.
// Backpressure: exercised through full lanes; ovf_err checked when EDA_FIFO_BANK_OVF_CHECK_EN is defined.
module tb_eda_fifo_bank;
   logic clk;
   logic reset;
   int   total;
   int   bad;
`ifdef EDA_FIFO_BANK_OVF_CHECK_EN
   logic ovf_err;
`endif

   eda_fifo_bank_if #(.WINDOW_WIDTH(9), .ADDR_WIDTH(8)) bus ();

   eda_fifo_bank #(
      .WINDOW_WIDTH (9),
      .ADDR_WIDTH   (8),
      .I_WIDTH      (4),
      .J_WIDTH      (4),
      .FIFO_DEPTH   (16)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus)
`ifdef EDA_FIFO_BANK_OVF_CHECK_EN
      ,
      .ovf_err (ovf_err)
`endif
   );

   typedef struct {
      logic       clr;
      logic [7:0] ca;
      logic [7:0] push;
      logic [7:0] rd;
      logic [7:0] exp_dout;
      logic [7:0] exp_empty;
      logic [7:0] exp_full;
   } vec_t;

   vec_t vecs [22];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // One clock: drive at negedge, check head before the edge, status after it.
   task automatic step(input string nm, input logic clr, input logic [7:0] ca, input logic [7:0] push,
                       input logic [7:0] rd, input logic [7:0] exp_dout, input logic [7:0] exp_empty,
                       input logic [7:0] exp_full);
      @(negedge clk);
      bus.clear          = clr;
      bus.center_addr    = ca;
      bus.push_positions = push;
      bus.read_en        = rd;
      #1;
      check({nm, ".dout"}, 32'(bus.data_out), 32'(exp_dout));
      @(posedge clk);
      #1;
      check({nm, ".empty"}, 32'(bus.fifo_empty), 32'(exp_empty));
      check({nm, ".full"}, 32'(bus.fifo_full), 32'(exp_full));
   endtask

   task automatic idle_inputs();
      bus.clear          = 1'b0;
      bus.center_addr    = 8'h00;
      bus.push_positions = 8'h00;
      bus.read_en        = 8'h00;
   endtask

   initial begin
      total = 0;
      bad   = 0;

      // clr, centre, push, read, data_out, empty-after, full-after
      vecs[0]  = '{1'b0, 8'h55, 8'h01, 8'h00, 8'h00, 8'hFE, 8'h00};
      vecs[1]  = '{1'b0, 8'h55, 8'h00, 8'h01, 8'h44, 8'hFF, 8'h00};
      vecs[2]  = '{1'b0, 8'h55, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
      vecs[3]  = '{1'b0, 8'h55, 8'h00, 8'h0A, 8'h45, 8'h02, 8'h00};
      vecs[4]  = '{1'b0, 8'h55, 8'h00, 8'h80, 8'h66, 8'h82, 8'h00};
      vecs[5]  = '{1'b0, 8'h55, 8'h00, 8'h08, 8'h54, 8'h8A, 8'h00};
      vecs[6]  = '{1'b0, 8'h55, 8'h00, 8'h02, 8'h00, 8'h8A, 8'h00};
      vecs[7]  = '{1'b0, 8'h55, 8'h00, 8'h04, 8'h46, 8'h8E, 8'h00};
      vecs[8]  = '{1'b0, 8'h55, 8'h00, 8'h10, 8'h56, 8'h9E, 8'h00};
      vecs[9]  = '{1'b0, 8'h55, 8'h00, 8'h20, 8'h64, 8'hBE, 8'h00};
      vecs[10] = '{1'b0, 8'h55, 8'h00, 8'h40, 8'h65, 8'hFE, 8'h00};
      vecs[11] = '{1'b0, 8'h55, 8'h00, 8'h01, 8'h44, 8'hFF, 8'h00};
      vecs[12] = '{1'b0, 8'h00, 8'h01, 8'h00, 8'h00, 8'hFE, 8'h00};
      vecs[13] = '{1'b0, 8'hFF, 8'h10, 8'h01, 8'hFF, 8'hEF, 8'h00};
      vecs[14] = '{1'b0, 8'h55, 8'h00, 8'h10, 8'hF0, 8'hFF, 8'h00};
      vecs[15] = '{1'b0, 8'h55, 8'h01, 8'h01, 8'h00, 8'hFE, 8'h00};
      vecs[16] = '{1'b0, 8'h00, 8'h01, 8'h01, 8'h44, 8'hFE, 8'h00};
      vecs[17] = '{1'b0, 8'h55, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'h00};
      vecs[18] = '{1'b0, 8'h55, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
      vecs[19] = '{1'b1, 8'h55, 8'hFF, 8'h01, 8'h44, 8'hFF, 8'h00};
      vecs[20] = '{1'b0, 8'h55, 8'h00, 8'h01, 8'h00, 8'hFF, 8'h00};
      vecs[21] = '{1'b0, 8'h55, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00};

      // Reset state
      reset = 1'b1;
      idle_inputs();
      #1;
      check("rst.empty", 32'(bus.fifo_empty), 32'hFF);
      check("rst.full", 32'(bus.fifo_full), 32'h00);
      check("rst.dout", 32'(bus.data_out), 32'h00);
`ifdef EDA_FIFO_BANK_OVF_CHECK_EN
      check("rst.ovf", 32'(ovf_err), 32'h0);
`endif
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Table-driven vectors
      for (int i = 0; i < 22; i++) begin
         step($sformatf("vec%0d", i), vecs[i].clr, vecs[i].ca, vecs[i].push, vecs[i].rd,
              vecs[i].exp_dout, vecs[i].exp_empty, vecs[i].exp_full);
      end

      // Fill lane 0 with 16 distinct entries, then one more that must be dropped
      for (int k = 0; k < 16; k++) begin
         step($sformatf("fill0_%0d", k), 1'b0, {4'(k), 4'h5}, 8'h01, 8'h00, 8'h00, 8'hFE,
              (k == 15) ? 8'h01 : 8'h00);
      end
`ifdef EDA_FIFO_BANK_OVF_CHECK_EN
      check("fill0.ovf_before", 32'(ovf_err), 32'h0);
`endif
      step("fill0_17th", 1'b0, 8'hA5, 8'h01, 8'h00, 8'h00, 8'hFE, 8'h01);
`ifdef EDA_FIFO_BANK_OVF_CHECK_EN
      check("fill0.ovf_after", 32'(ovf_err), 32'h1);
`endif
      for (int k = 0; k < 16; k++) begin
         logic [3:0] r;
         r = 4'(k) - 4'd1;
         step($sformatf("drain0_%0d", k), 1'b0, 8'h55, 8'h00, 8'h01, {r, 4'h4},
              (k == 15) ? 8'hFF : 8'hFE, 8'h00);
      end

      // Clear also clears the sticky flag
      step("clr", 1'b1, 8'h55, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00);
`ifdef EDA_FIFO_BANK_OVF_CHECK_EN
      check("clr.ovf", 32'(ovf_err), 32'h0);
`endif

      // Full lane 2: simultaneous push and pop keeps it full and advances head
      for (int k = 0; k < 16; k++) begin
         step($sformatf("fill2_%0d", k), 1'b0, {4'(k), 4'h5}, 8'h04, 8'h00, 8'h00, 8'hFB,
              (k == 15) ? 8'h04 : 8'h00);
      end
      step("pp2", 1'b0, 8'h99, 8'h04, 8'h04, 8'hF6, 8'hFB, 8'h04);
`ifdef EDA_FIFO_BANK_OVF_CHECK_EN
      check("pp2.ovf", 32'(ovf_err), 32'h0);
`endif
      for (int k = 1; k < 16; k++) begin
         logic [3:0] r;
         r = 4'(k) - 4'd1;
         step($sformatf("drain2_%0d", k), 1'b0, 8'h55, 8'h00, 8'h04, {r, 4'h6}, 8'hFB, 8'h00);
      end
      step("drain2_last", 1'b0, 8'h55, 8'h00, 8'h04, 8'h8A, 8'hFF, 8'h00);

      // Reset asserted mid-stream takes effect without a clock edge
      step("pre_rst", 1'b0, 8'h55, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
      @(negedge clk);
      idle_inputs();
      reset = 1'b1;
      #1;
      check("midrst.empty", 32'(bus.fifo_empty), 32'hFF);
      check("midrst.full", 32'(bus.fifo_full), 32'h00);
      @(negedge clk);
      reset = 1'b0;
      step("post_rst_push", 1'b0, 8'h55, 8'h01, 8'h00, 8'h00, 8'hFE, 8'h00);
      step("post_rst_pop", 1'b0, 8'h55, 8'h00, 8'h01, 8'h44, 8'hFF, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
